net_recv_event_dispatch: RTL and testbench
==========================================

// Module: net_recv_event_dispatch
// PURPOSE
// Downstream of the NET_RECV controller barrier queues. Joins one event's per-argument streams:
//   NUM_SCALARS scalar channels plus one multi-beat 512b packet channel.
// Dispatches the whole event atomically to one of NUM_REPLICAS handler replicas, round-robin.
// Argument sets of different events never interleave at any replica.
// PARAMETERS
// NUM_SCALARS   8    scalar argument channels joined per event
// SCALAR_W      256  per-channel scalar width; narrower args are zero-padded in the MSBs upstream
// NUM_REPLICAS  4    handler replicas; must be >=2
// PKT_W         512  packet tdata width; tkeep is PKT_W/8
// CNT_W         32   event counter width (stats option only)
// PORTS
// clk            in   1                       clock
// rst            in   1                       reset; one clock; reset is asynchronous and active-low
// in_sc_tdata    in   NUM_SCALARS*SCALAR_W    scalar args; channel i at [i*SCALAR_W +: SCALAR_W]
// in_sc_tvalid   in   NUM_SCALARS             per-channel valid
// in_sc_tready   out  NUM_SCALARS             per-channel ready
// in_pkt_tdata   in   PKT_W                   packet beat data
// in_pkt_tkeep   in   PKT_W/8                 byte enables
// in_pkt_tlast   in   1                       last beat of the event's packet
// in_pkt_tvalid  in   1                       packet valid
// in_pkt_tready  out  1                       packet ready
// out_sc_tdata   out  NUM_SCALARS*SCALAR_W    registered scalar bundle, shared by all replicas
// out_sc_tvalid  out  NUM_REPLICAS            one-hot; only the target replica is asserted
// out_sc_tready  in   NUM_REPLICAS            per-replica scalar ready
// out_pkt_tdata/tkeep/tlast  out  PKT_W,PKT_W/8,1  shared; wired straight from in_pkt_*
// out_pkt_tvalid out  NUM_REPLICAS            one-hot, target replica only
// out_pkt_tready in   NUM_REPLICAS            per-replica packet ready
// busy           out  1                       high when state != IDLE
// cur_replica    out  $clog2(NUM_REPLICAS)    locked target; value meaningful only while busy
// BEHAVIOUR
// States: IDLE, XFER. Reset (async, rst=0) forces:
//   IDLE, rr_ptr=0, all out_*_tvalid=0, in_*_tready=0, out_sc_tdata=0, sc_done=0, pkt_done=0.
// IDLE:
//   in_sc_tready=0, in_pkt_tready=0.
//   Waits until &in_sc_tvalid && in_pkt_tvalid.
//   Target = first replica r, searching rr_ptr upward mod NUM_REPLICAS, with out_sc_tready[r]=1.
//   If no replica is ready, target = rr_ptr.
//   In that cycle in_sc_tready = all-ones (join; every scalar is popped together).
//   Scalars are captured into out_sc_tdata; target locked; -> XFER.
// XFER scalars:
//   out_sc_tvalid[target]=1 until out_sc_tready[target]; then sc_done=1.
//   Data is held stable while valid.
// XFER packet (0-cycle pass-through):
//   out_pkt_tvalid[target] = in_pkt_tvalid & !pkt_done.
//   in_pkt_tready = out_pkt_tready[target] & !pkt_done.
//   The beat with tlast accepted sets pkt_done.
// Exit: sc_done & pkt_done, counting a same-cycle final handshake.
//   Next cycle -> IDLE; rr_ptr = (target+1) mod NUM_REPLICAS; done flags cleared.
// Scalar handshake and tlast beat in the same cycle: exit happens that cycle; no extra wait.
// Latency: scalars reach the replica 1 cycle after the join; packet beats 0 cycles.
// Minimum 1 IDLE cycle between events, so peak rate is one event per (beats+1) cycles.
// In IDLE, an in_pkt_tvalid=1 while a scalar channel is still invalid is not consumed (no partial join).
// Reset mid-XFER: event is dropped; upstream shares the reset, so no realignment is needed.
// rr_ptr wraps from NUM_REPLICAS-1 to 0. out_*_tvalid is never multi-hot.
// CONFIGURATION
// Macro NET_RECV_DISPATCH_STATS_EN.
// Defined: adds output evt_count [NUM_REPLICAS*CNT_W].
//   Per-replica count of completed events, incremented at XFER exit.
//   Wraps at 2^CNT_W; reset to 0.
// Undefined: port and counters are absent; all other behaviour is identical.
// STRUCTURE
// Shared package ep2_dispatch_pkg: typedef dispatch_state_e {IDLE,XFER}; PKT_W/KEEP_W constants.
// One sub-module, rr_pick: combinational search (req vector, ptr) -> index.
//   Reused by other event controllers.
// TESTING
// 1) Single event; all replicas ready; 3-beat packet.
//    -> replica 0 receives scalars 1 cycle after the join and beats 0..2; busy low after 4 cycles.
// 2) Four back-to-back 1-beat events, all ready.
//    -> targets 0,1,2,3, then 0 again; out_*_tvalid always one-hot.
// 3) rr_ptr=1 with out_sc_tready=4'b1001.
//    -> target 3; rr_ptr becomes 0 after the event.
// 4) Scalar channel 5 valid arrives 6 cycles late.
//    -> no ready asserted on any input until cycle 6, then all scalars popped together.
// 5) Target replica holds out_pkt_tready=0 for 10 cycles mid-packet.
//    -> in_pkt_tready=0; no beat is lost or duplicated; tlast completes the event.
// 6) rst pulsed low in XFER.
//    -> next cycle IDLE, all valids 0, rr_ptr=0; with the stats macro, counters read 0.

Source files
------------

// File: rtl/net_recv_event_dispatch_pkg.sv
// Shared types and constants for the event dispatch controllers.
package ep2_dispatch_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } dispatch_state_e;

    localparam int PKT_W  = 512;
    localparam int KEEP_W = PKT_W / 8;

endpackage

// File: rtl/net_recv_event_dispatch_rr_pick.sv
// Round-robin search: first set bit of req at or after ptr, wrapping modulo N.
// When nothing is requested, idx returns ptr and found is low.
module rr_pick #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        idx   = ptr;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/net_recv_event_dispatch.sv
// Joins scalar args and a multi-beat packet into one event and hands it to a round-robin replica.
// Optional per-replica completed-event counters: define NET_RECV_DISPATCH_STATS_EN.
module net_recv_event_dispatch
    import ep2_dispatch_pkg::*;
#(
    parameter int NUM_SCALARS  = 8,
    parameter int SCALAR_W     = 256,
    parameter int NUM_REPLICAS = 4,
    parameter int PKT_W        = ep2_dispatch_pkg::PKT_W,
    parameter int CNT_W        = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SCALARS*SCALAR_W-1:0]   in_sc_tdata,
    input  logic [NUM_SCALARS-1:0]            in_sc_tvalid,
    output logic [NUM_SCALARS-1:0]            in_sc_tready,
    input  logic [PKT_W-1:0]                  in_pkt_tdata,
    input  logic [PKT_W/8-1:0]                in_pkt_tkeep,
    input  logic                              in_pkt_tlast,
    input  logic                              in_pkt_tvalid,
    output logic                              in_pkt_tready,
    output logic [NUM_SCALARS*SCALAR_W-1:0]   out_sc_tdata,
    output logic [NUM_REPLICAS-1:0]           out_sc_tvalid,
    input  logic [NUM_REPLICAS-1:0]           out_sc_tready,
    output logic [PKT_W-1:0]                  out_pkt_tdata,
    output logic [PKT_W/8-1:0]                out_pkt_tkeep,
    output logic                              out_pkt_tlast,
    output logic [NUM_REPLICAS-1:0]           out_pkt_tvalid,
    input  logic [NUM_REPLICAS-1:0]           out_pkt_tready,
    output logic                              busy,
    output logic [$clog2(NUM_REPLICAS)-1:0]   cur_replica
`ifdef NET_RECV_DISPATCH_STATS_EN
    ,
    output logic [NUM_REPLICAS*CNT_W-1:0]     evt_count
`endif
);

    localparam int REP_W = $clog2(NUM_REPLICAS);

    if (NUM_REPLICAS < 2 || CNT_W < 1) begin : g_param_check
        $error("net_recv_event_dispatch: NUM_REPLICAS must be >= 2 and CNT_W >= 1");
    end

    dispatch_state_e                 state_q, state_d;
    logic [REP_W-1:0]                rr_ptr_q;
    logic [REP_W-1:0]                target_q;
    logic [REP_W-1:0]                pick_idx;
    logic [REP_W-1:0]                start_target;
    logic                            pick_found;
    logic [NUM_SCALARS*SCALAR_W-1:0] sc_data_q;
    logic                            sc_done_q;
    logic                            pkt_done_q;
    logic                            join_ok;
    logic                            sc_hs;
    logic                            pkt_last_hs;
    logic                            xfer_exit;

    rr_pick #(.N(NUM_REPLICAS)) u_rr_pick (
        .req   (out_sc_tready),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // With no replica ready the event still locks onto rr_ptr and waits there.
    assign start_target = pick_found ? pick_idx : rr_ptr_q;

    assign join_ok     = (&in_sc_tvalid) & in_pkt_tvalid;
    assign sc_hs       = (state_q == XFER) & ~sc_done_q & out_sc_tready[target_q];
    assign pkt_last_hs = in_pkt_tvalid & in_pkt_tready & in_pkt_tlast;
    assign xfer_exit   = (state_q == XFER) & (sc_done_q | sc_hs) & (pkt_done_q | pkt_last_hs);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (join_ok)   state_d = XFER;
            XFER:    if (xfer_exit) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_sc_tready   = '0;
        in_pkt_tready  = 1'b0;
        out_sc_tvalid  = '0;
        out_pkt_tvalid = '0;
        unique case (state_q)
            IDLE: if (join_ok && rst) in_sc_tready = '1;
            XFER: begin
                out_sc_tvalid[target_q]  = ~sc_done_q;
                out_pkt_tvalid[target_q] = in_pkt_tvalid & ~pkt_done_q;
                in_pkt_tready            = out_pkt_tready[target_q] & ~pkt_done_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q   <= '0;
            target_q   <= '0;
            sc_data_q  <= '0;
            sc_done_q  <= 1'b0;
            pkt_done_q <= 1'b0;
        end else if (state_q == IDLE && join_ok) begin
            sc_data_q  <= in_sc_tdata;
            target_q   <= start_target;
            sc_done_q  <= 1'b0;
            pkt_done_q <= 1'b0;
        end else if (xfer_exit) begin
            rr_ptr_q   <= (target_q == REP_W'(NUM_REPLICAS - 1)) ? '0 : target_q + 1'b1;
            sc_done_q  <= 1'b0;
            pkt_done_q <= 1'b0;
        end else if (state_q == XFER) begin
            if (sc_hs)       sc_done_q  <= 1'b1;
            if (pkt_last_hs) pkt_done_q <= 1'b1;
        end
    end

    assign out_sc_tdata  = sc_data_q;
    assign out_pkt_tdata = in_pkt_tdata;
    assign out_pkt_tkeep = in_pkt_tkeep;
    assign out_pkt_tlast = in_pkt_tlast;
    assign busy          = (state_q == XFER);
    assign cur_replica   = target_q;

`ifdef NET_RECV_DISPATCH_STATS_EN
    logic [CNT_W-1:0] evt_cnt_q [NUM_REPLICAS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REPLICAS; i++) evt_cnt_q[i] <= '0;
        end else if (xfer_exit) begin
            evt_cnt_q[target_q] <= evt_cnt_q[target_q] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_REPLICAS; g++) begin : g_evt
        assign evt_count[g*CNT_W +: CNT_W] = evt_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_net_recv_event_dispatch.sv
// Scoreboard bench for net_recv_event_dispatch; expectations are queued at the join and popped at replica handshakes.
module tb_net_recv_event_dispatch;
    import ep2_dispatch_pkg::*;

    localparam int NS = 8;
    localparam int SW = 256;
    localparam int NR = 4;
    localparam int PW = PKT_W;
    localparam int KW = KEEP_W;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NS*SW-1:0]  in_sc_tdata = '0;
    logic [NS-1:0]     in_sc_tvalid = '0;
    logic [NS-1:0]     in_sc_tready;
    logic [PW-1:0]     in_pkt_tdata = '0;
    logic [KW-1:0]     in_pkt_tkeep = '0;
    logic              in_pkt_tlast = 1'b0;
    logic              in_pkt_tvalid = 1'b0;
    logic              in_pkt_tready;
    logic [NS*SW-1:0]  out_sc_tdata;
    logic [NR-1:0]     out_sc_tvalid;
    logic [NR-1:0]     out_sc_tready = '1;
    logic [PW-1:0]     out_pkt_tdata;
    logic [KW-1:0]     out_pkt_tkeep;
    logic              out_pkt_tlast;
    logic [NR-1:0]     out_pkt_tvalid;
    logic [NR-1:0]     out_pkt_tready = '1;
    logic              busy;
    logic [1:0]        cur_replica;
`ifdef NET_RECV_DISPATCH_STATS_EN
    logic [NR*CW-1:0]  evt_count;
    int                evt_m [NR];
`endif

    always #5 clk = ~clk;

    net_recv_event_dispatch u_dut (
`ifdef NET_RECV_DISPATCH_STATS_EN
        .evt_count      (evt_count),
`endif
        .clk            (clk),
        .rst            (rst),
        .in_sc_tdata    (in_sc_tdata),
        .in_sc_tvalid   (in_sc_tvalid),
        .in_sc_tready   (in_sc_tready),
        .in_pkt_tdata   (in_pkt_tdata),
        .in_pkt_tkeep   (in_pkt_tkeep),
        .in_pkt_tlast   (in_pkt_tlast),
        .in_pkt_tvalid  (in_pkt_tvalid),
        .in_pkt_tready  (in_pkt_tready),
        .out_sc_tdata   (out_sc_tdata),
        .out_sc_tvalid  (out_sc_tvalid),
        .out_sc_tready  (out_sc_tready),
        .out_pkt_tdata  (out_pkt_tdata),
        .out_pkt_tkeep  (out_pkt_tkeep),
        .out_pkt_tlast  (out_pkt_tlast),
        .out_pkt_tvalid (out_pkt_tvalid),
        .out_pkt_tready (out_pkt_tready),
        .busy           (busy),
        .cur_replica    (cur_replica)
    );

    typedef struct {
        int              rep;
        logic [NS*SW-1:0] data;
    } sc_exp_t;

    typedef struct {
        int            rep;
        logic [PW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } pkt_exp_t;

    sc_exp_t  sc_q [$];
    pkt_exp_t pkt_q [$];
    sc_exp_t  mon_sc;
    pkt_exp_t mon_pkt;
    int       n_cmp = 0;
    int       n_err = 0;
    int       rr_m = 0;
    int       pkt_hs_cnt = 0;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick_model(input int rr, input logic [NR-1:0] rdy);
        for (int k = 0; k < NR; k++)
            if (rdy[(rr + k) % NR]) return (rr + k) % NR;
        return rr;
    endfunction

    function automatic int oh2idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [SW-1:0] rnd_sc();
        logic [SW-1:0] r;
        for (int i = 0; i < SW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [PW-1:0] rnd_pkt();
        logic [PW-1:0] r;
        for (int i = 0; i < PW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Replica-side monitor: one-hot valids and scoreboard pops on every handshake.
    always @(negedge clk) begin
        if (rst) begin
            check("onehot", PW'($onehot0(out_sc_tvalid) && $onehot0(out_pkt_tvalid)), PW'(1));
            if (|(out_sc_tvalid & out_sc_tready)) begin
                check("sc_q_nonempty", PW'(sc_q.size() != 0), PW'(1));
                if (sc_q.size() != 0) begin
                    mon_sc = sc_q.pop_front();
                    check("sc_rep", PW'(oh2idx(out_sc_tvalid)), PW'(mon_sc.rep));
                    for (int ch = 0; ch < NS; ch++)
                        check("sc_data", PW'(out_sc_tdata[ch*SW +: SW]), PW'(mon_sc.data[ch*SW +: SW]));
                end
            end
            if (|(out_pkt_tvalid & out_pkt_tready)) begin
                pkt_hs_cnt++;
                check("pkt_pass_ready", PW'(in_pkt_tready), PW'(1));
                check("pkt_q_nonempty", PW'(pkt_q.size() != 0), PW'(1));
                if (pkt_q.size() != 0) begin
                    mon_pkt = pkt_q.pop_front();
                    check("pkt_rep", PW'(oh2idx(out_pkt_tvalid)), PW'(mon_pkt.rep));
                    check("pkt_data", out_pkt_tdata, mon_pkt.data);
                    check("pkt_keep", PW'(out_pkt_tkeep), PW'(mon_pkt.keep));
                    check("pkt_last", PW'(out_pkt_tlast), PW'(mon_pkt.last));
                end
            end
        end
    end

    // Drives one event; a scalar channel may be held invalid for late_cyc cycles.
    task automatic send_event(input int beats, input int late_ch, input int late_cyc,
                              output int join_cyc, output int idle_wait);
        logic [NS*SW-1:0] sc;
        logic [PW-1:0]    pd [$];
        logic [KW-1:0]    pk [$];
        int               tgt, cyc, b;
        bit               joined, hs, first;
        for (int ch = 0; ch < NS; ch++) sc[ch*SW +: SW] = rnd_sc();
        for (int i = 0; i < beats; i++) begin
            pd.push_back(rnd_pkt());
            pk.push_back({$urandom, $urandom});
        end
        in_sc_tdata  = sc;
        in_sc_tvalid = '1;
        if (late_ch >= 0) in_sc_tvalid[late_ch] = 1'b0;
        in_pkt_tdata  = pd[0];
        in_pkt_tkeep  = pk[0];
        in_pkt_tlast  = (beats == 1);
        in_pkt_tvalid = 1'b1;
        cyc = 0;
        tgt = 0;
        joined = 1'b0;
        while (!joined && cyc < 100) begin
            @(negedge clk);
            if (in_sc_tready == '1) begin
                joined = 1'b1;
                tgt = pick_model(rr_m, out_sc_tready);
                rr_m = (tgt + 1) % NR;
                sc_q.push_back('{rep: tgt, data: sc});
                for (int i = 0; i < beats; i++)
                    pkt_q.push_back('{rep: tgt, data: pd[i], keep: pk[i], last: (i == beats - 1)});
`ifdef NET_RECV_DISPATCH_STATS_EN
                evt_m[tgt]++;
`endif
            end else begin
                check("idle_sc_tready", PW'(in_sc_tready), PW'(0));
                check("idle_pkt_tready", PW'(in_pkt_tready), PW'(0));
            end
            @(posedge clk);
            #1;
            if (joined) begin
                in_sc_tvalid = '0;
                in_sc_tdata  = ~sc;
            end else begin
                cyc++;
                if (late_ch >= 0 && cyc == late_cyc) in_sc_tvalid[late_ch] = 1'b1;
            end
        end
        check("joined", PW'(joined), PW'(1));
        join_cyc = cyc;
        b = 0;
        first = 1'b1;
        while (joined && b < beats && cyc < 400) begin
            @(negedge clk);
            if (first) begin
                check("sc_valid_lat", PW'(out_sc_tvalid), PW'(1 << tgt));
                check("busy_xfer", PW'(busy), PW'(1));
                check("cur_replica", PW'(cur_replica), PW'(tgt));
                first = 1'b0;
            end
            hs = in_pkt_tready;
            @(posedge clk);
            #1;
            cyc++;
            if (hs) begin
                b++;
                if (b < beats) begin
                    in_pkt_tdata = pd[b];
                    in_pkt_tkeep = pk[b];
                    in_pkt_tlast = (b == beats - 1);
                end else begin
                    in_pkt_tvalid = 1'b0;
                    in_pkt_tlast  = 1'b0;
                end
            end
        end
        check("beats_sent", PW'(b), PW'(beats));
        in_pkt_tvalid = 1'b0;
        idle_wait = 0;
        @(negedge clk);
        while (busy && idle_wait < 100) begin
            @(negedge clk);
            idle_wait++;
        end
        check("busy_drop", PW'(busy), PW'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t reached limit", $time);
        $fatal(1, "watchdog expired");
    end

    int jc, iw, k, t5_tgt, t5_base;

    initial begin
        // Reset state
        #1;
        check("rst_busy", PW'(busy), PW'(0));
        check("rst_sc_valid", PW'(out_sc_tvalid), PW'(0));
        check("rst_pkt_valid", PW'(out_pkt_tvalid), PW'(0));
        check("rst_sc_ready", PW'(in_sc_tready), PW'(0));
        check("rst_pkt_ready", PW'(in_pkt_tready), PW'(0));
        for (int ch = 0; ch < NS; ch++) check("rst_sc_data", PW'(out_sc_tdata[ch*SW +: SW]), PW'(0));
`ifdef NET_RECV_DISPATCH_STATS_EN
        for (int r = 0; r < NR; r++) evt_m[r] = 0;
`endif
        #11 rst = 1'b1;
        @(posedge clk);
        #1;

        // 1) single event, 3 beats, all ready
        send_event(3, -1, 0, jc, iw);
        check("t1_join_cyc", PW'(jc), PW'(0));
        check("t1_busy_drop_wait", PW'(iw), PW'(0));

        // 2) back-to-back 1-beat events: scalar handshake and tlast share the exit cycle
        for (int e = 0; e < 4; e++) begin
            send_event(1, -1, 0, jc, iw);
            check("t2_join_cyc", PW'(jc), PW'(0));
            check("t2_busy_drop_wait", PW'(iw), PW'(0));
        end

        // 3) sparse scalar readiness, then wrap to replica 0
        out_sc_tready = 4'b1001;
        send_event(2, -1, 0, jc, iw);
        out_sc_tready = '1;
        send_event(1, -1, 0, jc, iw);

        // 4) scalar channel 5 arrives 6 cycles late
        send_event(2, 5, 6, jc, iw);
        check("t4_join_cyc", PW'(jc), PW'(6));

        // 5) target replica stalls its packet ready mid-packet
        t5_tgt  = pick_model(rr_m, out_sc_tready);
        t5_base = pkt_hs_cnt;
        fork
            send_event(5, -1, 0, jc, iw);
            begin
                k = 0;
                while (pkt_hs_cnt < t5_base + 2 && k < 100) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                out_pkt_tready = ~(NR'(1) << t5_tgt);
                repeat (10) begin
                    @(negedge clk);
                    check("t5_stall_tready", PW'(in_pkt_tready), PW'(0));
                    check("t5_stall_valid", PW'(out_pkt_tvalid), PW'(1 << t5_tgt));
                end
                @(posedge clk);
                #1;
                out_pkt_tready = '1;
            end
        join

        // 5b) no replica ready at the join: target falls back to rr_ptr
        out_sc_tready = '0;
        fork
            send_event(2, -1, 0, jc, iw);
            begin
                repeat (5) @(posedge clk);
                #1;
                out_sc_tready = '1;
            end
        join
        send_event(1, -1, 0, jc, iw);

`ifdef NET_RECV_DISPATCH_STATS_EN
        for (int r = 0; r < NR; r++) check("evt_count", PW'(evt_count[r*CW +: CW]), PW'(evt_m[r]));
`endif

        // 6) reset pulse while an event is stuck in XFER
        out_sc_tready  = '0;
        out_pkt_tready = '0;
        for (int ch = 0; ch < NS; ch++) in_sc_tdata[ch*SW +: SW] = rnd_sc();
        in_sc_tvalid  = '1;
        in_pkt_tdata  = rnd_pkt();
        in_pkt_tvalid = 1'b1;
        k = 0;
        while (in_sc_tready != '1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t6_joined", PW'(in_sc_tready), PW'({NS{1'b1}}));
        @(posedge clk);
        #1;
        in_sc_tvalid = '0;
        @(negedge clk);
        check("t6_busy_before", PW'(busy), PW'(1));
        #2 rst = 1'b0;
        #1;
        check("t6_busy", PW'(busy), PW'(0));
        check("t6_sc_valid", PW'(out_sc_tvalid), PW'(0));
        check("t6_pkt_valid", PW'(out_pkt_tvalid), PW'(0));
        check("t6_sc_ready", PW'(in_sc_tready), PW'(0));
        check("t6_pkt_ready", PW'(in_pkt_tready), PW'(0));
        check("t6_sc_data", PW'(out_sc_tdata[SW-1:0]), PW'(0));
        in_pkt_tvalid = 1'b0;
        sc_q.delete();
        pkt_q.delete();
        rr_m = 0;
`ifdef NET_RECV_DISPATCH_STATS_EN
        for (int r = 0; r < NR; r++) begin
            evt_m[r] = 0;
            check("t6_evt_count", PW'(evt_count[r*CW +: CW]), PW'(0));
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        out_sc_tready  = '1;
        out_pkt_tready = '1;
        send_event(2, -1, 0, jc, iw);
        check("t6_after_cur_replica", PW'(cur_replica), PW'(0));

        check("sc_q_drained", PW'(sc_q.size()), PW'(0));
        check("pkt_q_drained", PW'(pkt_q.size()), PW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
